// File: rtl/aes_pkg.sv
// Shared AES-128 arithmetic: GF(2^8) helpers, S-boxes, round constants,
// forward key-schedule step and the decipher FSM state type.
package aes_pkg;
  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, LAST, DONE} aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, t;
    r = 8'h01;
    t = a;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x, s;
    x = gf_inv(a);
    for (int i = 0; i < 8; i++)
      s[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] x;
    for (int i = 0; i < 8; i++)
      x[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
    return gf_inv(x ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless is_last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         is_last,
  output logic [127:0] state_out
);
  logic [127:0] sb, ark, mc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r is rotated right by r columns on the way back.
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 127 - 8*(r + 4*c);
      localparam int SRC = 127 - 8*(r + 4*((c + 4 - r) % 4));
      assign sb[DST -: 8] = inv_sbox(state_in[SRC -: 8]);
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  end

  assign ark       = sb ^ rk;
  assign state_out = is_last ? ark : mc;
endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Optional AES_DEC_KEY_REUSE_EN skips key expansion when the key repeats.
module aes_decipher
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int BLK_W = AES_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] datain,
  input  logic [BLK_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] dataout,
  output logic             busy
);
  if (NR != 10) begin : g_bad_nr
    $error("aes_decipher supports NR=10 only");
  end
  if (BLK_W != 128) begin : g_bad_blk
    $error("aes_decipher supports BLK_W=128 only");
  end

  aes_fsm_e         fsm;
  logic [3:0]       rnd, rnd_m1;
  logic [BLK_W-1:0] blk, rk_sel, round_out;
  logic [BLK_W-1:0] rk [0:NR];
`ifdef AES_DEC_KEY_REUSE_EN
  logic             key_ok;
`endif

  assign rnd_m1 = rnd - 4'd1;
  assign rk_sel = rk[rnd];

  // rnd is 0 in LAST, so the same datapath applies rk[0] for the final round.
  aes_inv_round u_round (
    .state_in  (blk),
    .rk        (rk_sel),
    .is_last   (fsm == LAST),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      blk       <= '0;
      dataout   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_REUSE_EN
      key_ok    <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: if (in_valid && in_ready) begin
          blk      <= datain;
          rk[0]    <= key;
          rnd      <= 4'd1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef AES_DEC_KEY_REUSE_EN
          if (key_ok && key == rk[0]) begin
            fsm <= ADDKEY;
          end else begin
            key_ok <= 1'b0;
            fsm    <= KEYEXP;
          end
`else
          fsm      <= KEYEXP;
`endif
        end
        KEYEXP: begin
          rk[rnd] <= key_expand(rk[rnd_m1], rcon(rnd));
          if (rnd == 4'(NR)) begin
            fsm <= ADDKEY;
`ifdef AES_DEC_KEY_REUSE_EN
            key_ok <= 1'b1;
`endif
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ADDKEY: begin
          blk <= blk ^ rk[NR];
          rnd <= 4'(NR - 1);
          fsm <= ROUND;
        end
        ROUND: begin
          blk <= round_out;
          rnd <= rnd_m1;
          if (rnd == 4'd1) fsm <= LAST;
        end
        LAST: begin
          dataout   <= round_out;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decipher.sv
// Bench for aes_decipher: FIPS-197 vectors, backpressure, mid-job reset,
// back-to-back jobs and (with AES_DEC_KEY_REUSE_EN) key reuse latency.
module tb_aes_decipher;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] datain, key, dataout;

  aes_decipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] key, ct, pt; } vec_t;
  typedef struct { logic [127:0] pt; int lat; } exp_t;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  vec_t vt [2];
  exp_t sb [$];
  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0, hs_cyc = 0;
  logic ov_prev = 1'b0;
`ifdef AES_DEC_KEY_REUSE_EN
  logic         m_ok = 1'b0;
  logic [127:0] m_key = '0;
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic push_exp(input logic [127:0] k, input logic [127:0] p);
    exp_t e;
    e.pt  = p;
    e.lat = 21;
`ifdef AES_DEC_KEY_REUSE_EN
    if (m_ok && k == m_key) e.lat = 11;
    m_ok  = 1'b1;
    m_key = k;
`endif
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor; inputs only change just after posedge, so a negedge
  // sample shows exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
        else chk("latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        chk("plaintext", dataout, sb[0].pt);
        void'(sb.pop_front());
        hs_cyc = cyc + 1;
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    key      = k;
    datain   = c;
    push_exp(k, p);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) fail_now("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    datain   = '1;
    key      = '1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) fail_now("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{K_C1, CT_C1, PT_C1};
    vt[1] = '{K_B, CT_B, PT_B};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; datain = '0; key = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dataout",   dataout,          128'(0));
    chk("rst_out_valid", 128'(out_valid),  128'(0));
    chk("rst_in_ready",  128'(in_ready),   128'(1));
    chk("rst_busy",      128'(busy),       128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Table-driven FIPS vectors, out_ready held high.
    for (int i = 0; i < 2; i++) begin
      send(vt[i].key, vt[i].ct, vt[i].pt);
      drain();
    end

    // Backpressure: output must hold while out_ready is low.
    @(posedge clk); #1 out_ready = 1'b0;
    send(K_C1, CT_C1, PT_C1);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("bp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp_dataout",   dataout,         PT_C1);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready",  128'(in_ready),  128'(0));
      chk("bp_busy",      128'(busy),      128'(1));
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    chk("bp_release_in_ready",  128'(in_ready),  128'(1));
    drain();

    // Reset during key expansion aborts the job.
    send(K_C1, CT_C1, PT_C1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
`ifdef AES_DEC_KEY_REUSE_EN
    m_ok = 1'b0;
`endif
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_dataout",   dataout,         128'(0));
    chk("abort_in_ready",  128'(in_ready),  128'(1));
    chk("abort_busy",      128'(busy),      128'(0));
    send(K_B, CT_B, PT_B);
    drain();

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    in_valid = 1'b1; key = K_C1; datain = CT_C1;
    push_exp(K_C1, PT_C1);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    key = K_B; datain = CT_B;
    push_exp(K_B, PT_B);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) fail_now("b2b_accept");
    else chk("b2b_gap", 128'(cyc), 128'(hs_cyc));
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

`ifdef AES_DEC_KEY_REUSE_EN
    send(K_C1, CT_C1, PT_C1);
    drain();
    send(K_C1, CT_C1, PT_C1);
    drain();
    send(K_B, CT_B, PT_B);
    drain();
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(sb.size()), 128'(0));
    chk("final_out_valid", 128'(out_valid), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
